// File: rtl/wc_tile_seq.sv
// wc_tile_seq: tile sequencer in front of the Winograd F(2,4) core.
// Collects a serial sample stream into overlapping 5-sample tiles (stride 2),
// drives each tile onto the core's D bus for the core latency, captures the
// two-word Z result and streams it out with an end-of-row marker.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   s_valid  / s_ready / s_data    sample input handshake
//   wc_D     tile to core, slot k = wc_D[DW*k +: DW], slot 0 oldest
//   wc_Z     core result, out j = wc_Z[DW*j +: DW]
//   m_valid  / m_ready / m_data    result output handshake
//   m_last   final result of a row
//   busy     a row is in progress
//
// state | meaning
// FILL  | accepting samples into the sliding window
// ISSUE | tile held on wc_D while the core settles
// DRAIN | emitting the two captured results
module wc_tile_seq #(
   parameter int DW      = 10,
   parameter int ROW_LEN = 17,
   parameter int WC_LAT  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DW-1:0]     s_data,
   output logic [5*DW-1:0]   wc_D,
   input  logic [2*DW-1:0]   wc_Z,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DW-1:0]     m_data,
   output logic              m_last,
   output logic              busy
);

   localparam int T  = (ROW_LEN - 3) / 2;
   localparam int TW = (T > 1) ? $clog2(T) : 1;
   localparam int LW = (WC_LAT > 0) ? $clog2(WC_LAT + 1) : 1;
   localparam logic [TW-1:0] T_LAST   = TW'(T - 1);
   localparam logic [LW-1:0] LAT_LAST = LW'(WC_LAT);

   typedef enum logic [1:0] {FILL, ISSUE, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [2:0]        fill_cnt_q, fill_cnt_d;
   logic [TW-1:0]     tile_cnt_q, tile_cnt_d;
   logic [LW-1:0]     lat_cnt_q, lat_cnt_d;
   logic              drain_idx_q, drain_idx_d;
   logic [5*DW-1:0]   window_q, window_d;
   logic [5*DW-1:0]   wc_d_q, wc_d_d;
   logic [2*DW-1:0]   z_buf_q, z_buf_d;
   logic [5*DW-1:0]   window_shift;

   // Newest sample enters slot 4, everything else moves one slot older.
   assign window_shift = {s_data, window_q[5*DW-1:DW]};

   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      tile_cnt_d  = tile_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      drain_idx_d = drain_idx_q;
      window_d    = window_q;
      wc_d_d      = wc_d_q;
      z_buf_d     = z_buf_q;

      s_ready = (state_q == FILL) && !rst;
      m_valid = (state_q == DRAIN);
      m_data  = '0;
      if (m_valid) begin
         m_data = drain_idx_q ? z_buf_q[DW +: DW] : z_buf_q[0 +: DW];
      end
      m_last  = m_valid && drain_idx_q && (tile_cnt_q == T_LAST);
      busy    = (state_q != FILL) || (fill_cnt_q != 3'd0);
      wc_D    = wc_d_q;

      case (state_q)
         FILL: begin
            if (s_valid && s_ready) begin
               window_d   = window_shift;
               fill_cnt_d = fill_cnt_q + 3'd1;
               if (fill_cnt_q == 3'd4) begin
                  // Present the completed tile from the first ISSUE cycle on.
                  wc_d_d    = window_shift;
                  lat_cnt_d = '0;
                  state_d   = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (lat_cnt_q == LAT_LAST) begin
               z_buf_d     = wc_Z;
               drain_idx_d = 1'b0;
               state_d     = DRAIN;
            end else begin
               lat_cnt_d = lat_cnt_q + LW'(1);
            end
         end
         DRAIN: begin
            if (m_ready) begin
               if (!drain_idx_q) begin
                  drain_idx_d = 1'b1;
               end else begin
                  drain_idx_d = 1'b0;
                  state_d     = FILL;
                  if (tile_cnt_q != T_LAST) begin
                     // Keep the 3 newest samples; two more complete the next tile.
                     tile_cnt_d = tile_cnt_q + TW'(1);
                     fill_cnt_d = 3'd3;
                  end else begin
                     tile_cnt_d = '0;
                     fill_cnt_d = 3'd0;
                  end
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FILL;
         fill_cnt_q  <= '0;
         tile_cnt_q  <= '0;
         lat_cnt_q   <= '0;
         drain_idx_q <= 1'b0;
         window_q    <= '0;
         wc_d_q      <= '0;
         z_buf_q     <= '0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         tile_cnt_q  <= tile_cnt_d;
         lat_cnt_q   <= lat_cnt_d;
         drain_idx_q <= drain_idx_d;
         window_q    <= window_d;
         wc_d_q      <= wc_d_d;
         z_buf_q     <= z_buf_d;
      end
   end

endmodule

// File: tb/tb_wc_tile_seq.sv
// Bench for wc_tile_seq with an identity core model: out 0 = slot 0, out 1 = slot 1.
module tb_wc_tile_seq;
   localparam int DW = 10;

   logic            clk = 1'b0;
   logic            rst, s_valid, s_ready, m_valid, m_ready, m_last, busy;
   logic [DW-1:0]   s_data, m_data;
   logic [5*DW-1:0] wc_D;
   logic [2*DW-1:0] wc_Z;

   always #5 clk = ~clk;

   assign wc_Z = {wc_D[2*DW-1:DW], wc_D[DW-1:0]};

   wc_tile_seq #(.DW(DW), .ROW_LEN(17), .WC_LAT(2)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .wc_D(wc_D), .wc_Z(wc_Z), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last), .busy(busy)
   );

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic [DW-1:0]   res_q[$];
   bit              last_q[$];
   logic [5*DW-1:0] tile_q[$];
   int              hsn_q[$];
   int              hs_cyc_q[$];
   int              last_cyc_q[$];
   int              mv_rise_q[$];
   int              busy_fall_q[$];
   int              busy_rise_q[$];
   int              hs_since = 0;
   logic            prev_s_ready = 1'b0, prev_m_valid = 1'b0, prev_busy = 1'b0;

   // Monitor: samples at the falling edge, inputs are driven 1 after the rising edge.
   always @(negedge clk) begin
      if (rst) begin
         prev_s_ready = 1'b0;
         prev_m_valid = 1'b0;
         prev_busy    = 1'b0;
      end else begin
         if (s_valid && s_ready) begin
            hs_since++;
            hs_cyc_q.push_back(cyc);
         end
         if (m_valid && m_ready) begin
            res_q.push_back(m_data);
            last_q.push_back(m_last);
            if (m_last) last_cyc_q.push_back(cyc);
         end
         if (m_valid && !prev_m_valid) mv_rise_q.push_back(cyc);
         if (!s_ready && prev_s_ready) begin
            tile_q.push_back(wc_D);
            hsn_q.push_back(hs_since);
            hs_since = 0;
         end
         if (busy && !prev_busy) busy_rise_q.push_back(cyc);
         if (!busy && prev_busy) busy_fall_q.push_back(cyc);
         prev_s_ready = s_ready;
         prev_m_valid = m_valid;
         prev_busy    = busy;
      end
   end

   task automatic clear_logs();
      res_q.delete(); last_q.delete(); tile_q.delete(); hsn_q.delete();
      hs_cyc_q.delete(); last_cyc_q.delete(); mv_rise_q.delete();
      busy_fall_q.delete(); busy_rise_q.delete();
      hs_since = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send(input int v);
      int  n = 0;
      bit  ok = 1'b0;
      s_valid = 1'b1;
      s_data  = DW'(v);
      while (!ok && n < 300) begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk); #1;
         n++;
      end
      s_valid = 1'b0;
      if (!ok) begin
         chk_cnt++;
         $display("FAIL send_timeout sample=%0d not accepted within 300 cycles", v);
      end
   endtask

   task automatic wait_results(input int n);
      int k = 0;
      while (res_q.size() < n && k < 400) begin
         @(posedge clk); #1;
         k++;
      end
      idle(3);
      chk_cnt++;
      if (res_q.size() !== n)
         $display("FAIL result_count got=%0d want=%0d", res_q.size(), n);
      else pass_cnt++;
   endtask

   function automatic logic [5*DW-1:0] tile_of(input int b);
      logic [5*DW-1:0] t;
      for (int k = 0; k < 5; k++) t[DW*k +: DW] = DW'(b + k);
      return t;
   endfunction

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      idle(3);
      @(negedge clk);
      chk_cnt++;
      if (s_ready !== 1'b0) $display("FAIL reset_s_ready_in_rst got=%b want=0", s_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({m_valid, m_last, m_data, wc_D, busy} !== '0)
         $display("FAIL reset_outputs m_valid=%b m_last=%b m_data=%0d wc_D=%h busy=%b want all 0",
                  m_valid, m_last, m_data, wc_D, busy);
      else pass_cnt++;
      chk_cnt++;
      if (s_ready !== 1'b1) $display("FAIL reset_s_ready_after got=%b want=1", s_ready);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_single_row();
      clear_logs();
      m_ready = 1'b1;
      for (int v = 1; v <= 17; v++) send(v);
      wait_results(14);
      for (int r = 0; r < res_q.size(); r++) begin
         chk_cnt++;
         if (res_q[r] !== DW'(1 + r)) $display("FAIL row_data idx=%0d got=%0d want=%0d", r, res_q[r], 1 + r);
         else pass_cnt++;
         chk_cnt++;
         if (last_q[r] !== (r == 13)) $display("FAIL row_last idx=%0d got=%b want=%b", r, last_q[r], r == 13);
         else pass_cnt++;
      end
      chk_cnt++;
      if (tile_q.size() !== 7) $display("FAIL tile_count got=%0d want=7", tile_q.size());
      else pass_cnt++;
      for (int i = 0; i < tile_q.size(); i++) begin
         chk_cnt++;
         if (tile_q[i] !== tile_of(1 + 2 * i))
            $display("FAIL stride_tile idx=%0d got=%h want=%h", i, tile_q[i], tile_of(1 + 2 * i));
         else pass_cnt++;
         chk_cnt++;
         if (hsn_q[i] !== ((i == 0) ? 5 : 2))
            $display("FAIL stride_handshakes idx=%0d got=%0d want=%0d", i, hsn_q[i], (i == 0) ? 5 : 2);
         else pass_cnt++;
      end
      chk_cnt++;
      if (mv_rise_q.size() < 1 || hs_cyc_q.size() < 5)
         $display("FAIL first_latency missing events rises=%0d hs=%0d", mv_rise_q.size(), hs_cyc_q.size());
      else if (mv_rise_q[0] - hs_cyc_q[4] !== 4)
         $display("FAIL first_latency got=%0d want=4", mv_rise_q[0] - hs_cyc_q[4]);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int bad_v = 0, bad_d = 0, bad_s = 0, grew = 0, n0;
      clear_logs();
      m_ready = 1'b1;
      fork
         for (int v = 1; v <= 17; v++) send(v);
         begin
            int n = 0;
            while (!(m_valid && m_data == DW'(5)) && n < 500) begin
               @(posedge clk); #1;
               n++;
            end
            m_ready = 1'b0;
            n0 = res_q.size();
            repeat (5) begin
               @(negedge clk);
               if (m_valid !== 1'b1) bad_v++;
               if (m_data !== DW'(5)) bad_d++;
               if (s_ready !== 1'b0) bad_s++;
               @(posedge clk); #1;
            end
            if (res_q.size() != n0) grew = 1;
            m_ready = 1'b1;
         end
      join
      wait_results(14);
      chk_cnt++;
      if (bad_v !== 0) $display("FAIL bp_m_valid_hold bad_cycles=%0d want=0", bad_v);
      else pass_cnt++;
      chk_cnt++;
      if (bad_d !== 0) $display("FAIL bp_m_data_hold bad_cycles=%0d want=0", bad_d);
      else pass_cnt++;
      chk_cnt++;
      if (bad_s !== 0) $display("FAIL bp_s_ready_low bad_cycles=%0d want=0", bad_s);
      else pass_cnt++;
      chk_cnt++;
      if (grew !== 0) $display("FAIL bp_no_accept got=%0d want=0", grew);
      else pass_cnt++;
      for (int r = 0; r < res_q.size(); r++) begin
         chk_cnt++;
         if (res_q[r] !== DW'(1 + r)) $display("FAIL bp_data idx=%0d got=%0d want=%0d", r, res_q[r], 1 + r);
         else pass_cnt++;
      end
   endtask

   task automatic test_two_rows();
      clear_logs();
      m_ready = 1'b1;
      for (int v = 1; v <= 34; v++) begin
         idle($urandom_range(0, 3));
         send(v);
      end
      wait_results(28);
      for (int r = 0; r < res_q.size(); r++) begin
         int want;
         want = (r < 14) ? (1 + r) : (18 + r - 14);
         chk_cnt++;
         if (res_q[r] !== DW'(want)) $display("FAIL rows_data idx=%0d got=%0d want=%0d", r, res_q[r], want);
         else pass_cnt++;
         chk_cnt++;
         if (last_q[r] !== (r == 13 || r == 27))
            $display("FAIL rows_last idx=%0d got=%b want=%b", r, last_q[r], r == 13 || r == 27);
         else pass_cnt++;
      end
      chk_cnt++;
      if (tile_q.size() !== 14 || tile_q[7] !== tile_of(18))
         $display("FAIL row2_tile0 tiles=%0d got=%h want=%h", tile_q.size(),
                  (tile_q.size() > 7) ? tile_q[7] : '0, tile_of(18));
      else pass_cnt++;
      chk_cnt++;
      if (busy_fall_q.size() !== 2 || busy_rise_q.size() !== 2 || last_cyc_q.size() !== 2 || hs_cyc_q.size() !== 34)
         $display("FAIL busy_edges falls=%0d rises=%0d lasts=%0d hs=%0d want 2/2/2/34",
                  busy_fall_q.size(), busy_rise_q.size(), last_cyc_q.size(), hs_cyc_q.size());
      else pass_cnt++;
      if (busy_fall_q.size() == 2 && busy_rise_q.size() == 2 && last_cyc_q.size() == 2 && hs_cyc_q.size() == 34) begin
         chk_cnt++;
         if (busy_fall_q[0] !== last_cyc_q[0] + 1)
            $display("FAIL busy_fall got=%0d want=%0d", busy_fall_q[0], last_cyc_q[0] + 1);
         else pass_cnt++;
         chk_cnt++;
         if (busy_rise_q[1] !== hs_cyc_q[17] + 1)
            $display("FAIL busy_rise got=%0d want=%0d", busy_rise_q[1], hs_cyc_q[17] + 1);
         else pass_cnt++;
      end
   endtask

   task automatic test_mid_drain_reset();
      int n = 0;
      clear_logs();
      m_ready = 1'b0;
      for (int v = 50; v <= 54; v++) send(v);
      while (!m_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk_cnt++;
      if (m_valid !== 1'b1) $display("FAIL mdr_m_valid_wait got=%b want=1", m_valid);
      else pass_cnt++;
      rst = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (s_ready !== 1'b0) $display("FAIL mdr_s_ready_in_rst got=%b want=0", s_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if ({m_valid, m_last, m_data, wc_D, busy} !== '0)
         $display("FAIL mdr_outputs m_valid=%b m_last=%b m_data=%0d wc_D=%h busy=%b want all 0",
                  m_valid, m_last, m_data, wc_D, busy);
      else pass_cnt++;
      chk_cnt++;
      if (s_ready !== 1'b1) $display("FAIL mdr_s_ready got=%b want=1", s_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      clear_logs();
      m_ready = 1'b1;
      for (int v = 100; v <= 116; v++) send(v);
      wait_results(14);
      if (res_q.size() >= 14) begin
         chk_cnt++;
         if (res_q[0] !== DW'(100) || res_q[1] !== DW'(101))
            $display("FAIL mdr_first_results got=(%0d,%0d) want=(100,101)", res_q[0], res_q[1]);
         else pass_cnt++;
         chk_cnt++;
         if (res_q[13] !== DW'(113) || last_q[13] !== 1'b1)
            $display("FAIL mdr_row_end got=%0d last=%b want=113 last=1", res_q[13], last_q[13]);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_single_row();
      test_backpressure();
      test_two_rows();
      test_mid_drain_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout sim time limit reached");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/wc_tile_seq.md
# wc_tile_seq

Tile sequencer for the Winograd F(2,4) core `WC`. It accepts a serial stream of DW-bit samples over a valid/ready handshake and assembles overlapping 5-sample input tiles with stride 2. Each tile is presented on the core's 50-bit `D` bus and held for the core's fixed latency, after which the 20-bit `Z` result is captured. The two results are then emitted serially with valid/ready and an end-of-row marker. It sits between the chip input staging and `WC`, and replaces direct pad-to-core wiring of `D`/`Z`.

## Interface
- DW, 10: sample and result width
- ROW_LEN, 17: samples per row; must be odd and ≥5; tiles per row T = (ROW_LEN-3)/2
- WC_LAT, 2: cycles from a `D` change to a valid `Z` (≥0)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  sequencer can accept a sample
- s_data  in  DW  input sample
- wc_D  out  5*DW  tile to core; slot k = wc_D[DW*k +: DW], k=0 oldest
- wc_Z  in  2*DW  core result; out j = wc_Z[DW*j +: DW]
- m_valid  out  1  output result valid
- m_ready  in  1  downstream accepts
- m_data  out  DW  output result
- m_last  out  1  marks the final result of a row
- busy  out  1  a row is in progress

## Operation
- Reset, applied on any edge where rst=1: state FILL, fill_cnt=0, tile_cnt=0, lat_cnt=0, drain_idx=0, window=0, z_buf=0. All outputs read 0: s_ready, wc_D, m_valid, m_data, m_last, busy. s_ready is forced to 0 in any cycle where rst=1.
- FILL
  - s_ready=1.
  - Each handshake (s_valid & s_ready) shifts the window: slot k←slot k+1, and slot 4←s_data. fill_cnt increments.
  - The tile is complete when fill_cnt reaches 5. Go to ISSUE on that edge.
- ISSUE
  - s_ready=0. wc_D = window, held constant.
  - lat_cnt counts 0..WC_LAT. On the edge ending lat_cnt==WC_LAT, capture z_buf←wc_Z and go to DRAIN.
- DRAIN
  - m_valid=1. m_data = z_buf out 0, then out 1 (selected by drain_idx).
  - drain_idx advances only on the m_valid&m_ready edge.
  - m_last=1 only while emitting out 1 of tile T-1.
  - When out 1 is accepted:
    - If tile_cnt<T-1: tile_cnt++, fill_cnt←3 (the 3 newest samples are retained), go to FILL. The next tile needs exactly 2 new samples, giving stride 2.
    - Else: tile_cnt←0, fill_cnt←0, go to FILL. A new row needs 5 samples.
- wc_D keeps its last value outside ISSUE. The core output is sampled only at the capture edge.
- busy = (state≠FILL) | (fill_cnt≠0).
- No arithmetic is done on data. Samples and results pass bit-exact.
- Counter widths: tile_cnt ⌈log2 T⌉, lat_cnt ⌈log2(WC_LAT+1)⌉.
- No overlap: input is stalled from ISSUE entry until the last result of the tile is accepted.

## Timing
- Let the completing input handshake occur in cycle t:
  - ISSUE occupies cycles t+1..t+1+WC_LAT.
  - z_buf is loaded at the end of cycle t+1+WC_LAT.
  - m_valid=1 from cycle t+2+WC_LAT. With WC_LAT=2, m_valid rises in cycle t+4.
- wc_D is valid from cycle t+1.
- With m_ready held high, the two results take 2 cycles, and s_ready returns in the cycle after out 1 is accepted.
- m_data/m_valid/m_last stay stable while m_valid=1 & m_ready=0.
- s_valid while s_ready=0 is ignored; data is not consumed.
- Reset mid-tile or mid-drain discards the partial window and any pending results. The first post-reset row starts from fill_cnt=0.
- WC_LAT=0: ISSUE lasts exactly 1 cycle.

## Test plan
- Single row, ROW_LEN=17, WC_LAT=2, samples 1..17, m_ready=1, identity core model (Z = {D slot1, D slot0}):
  - Expect 7 tiles.
  - Results in order (1,2),(3,4),…,(13,14).
  - m_last only on result 14.
  - First m_valid 4 cycles after sample 5's handshake.
- Stride check: record wc_D per ISSUE.
  - Tile 0 = {1,2,3,4,5}; tile 1 = {3,4,5,6,7}; tile 6 = {13,…,17}.
  - Exactly 2 input handshakes occur between consecutive ISSUEs.
- Backpressure: m_ready low for 5 cycles during out 0 of tile 2.
  - m_data holds 5 and m_valid holds 1.
  - s_ready stays 0.
  - No sample is lost.
- Bubbles and two rows: random s_valid gaps, 34 samples.
  - Second row tile 0 = {18,…,22}.
  - busy=0 exactly between row 1's final accept and sample 18's handshake.
- Mid-drain reset: assert rst for 1 cycle while m_valid=1.
  - Next cycle all outputs are 0, s_ready=1.
  - A fresh row 100..116 yields first results (100,101).
